decrypt_ctrl: RTL and testbench
===============================

DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

Interface
REQ-001 The block SHALL provide the parameter BASE_ENC, default 64, which is the data-memory address of encrypted byte 0.
REQ-002 The block SHALL provide the parameter PRE_MIN, default 10, which is the guaranteed minimum count of space-character (0x20) preamble bytes.
REQ-003 The block SHALL provide the port Clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL provide the port Reset_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 The block SHALL provide the port Start, input, 1 bit: while high it holds the block idle, and a high-to-low transition launches a run.
REQ-006 The block SHALL provide the port Ack, output, 1 bit: it indicates that the run is complete.
REQ-007 The block SHALL provide the port Err, output, 1 bit: it indicates that no tap pattern matched, and it is valid whenever Ack is high.
REQ-008 The block SHALL provide the port mem_addr, output, 8 bits: the shared data-memory address used for both reads and writes.
REQ-009 The block SHALL provide the port mem_rd_data, input, 8 bits: data memory read data, valid one cycle after mem_addr is driven.
REQ-010 The block SHALL provide the port mem_wr_en, output, 1 bit: the data memory write strobe, written on the rising edge.
REQ-011 The block SHALL provide the port mem_wr_data, output, 8 bits: the data memory write data.
REQ-012 The block SHALL provide the port tap_sel, output, 4 bits: the index (0-8) of the selected tap pattern, valid whenever Ack is high.

Function
REQ-013 The block SHALL hold an internal constant table of 9 seven-bit tap patterns, in index order 0-8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
REQ-014 The LFSR step SHALL be s_next = {s[5:0], ^(s & tap)}, operating on 7 bits only.
REQ-015 Encrypted byte c[7] SHALL be treated as parity and ignored; only c[6:0] SHALL take part in the arithmetic.
REQ-016 The states SHALL be IDLE, INIT_RD, INIT, SRCH_RD, SRCH_CMP, DEC_RD, DEC_WR, DONE.
REQ-017 IDLE: the block SHALL leave IDLE to INIT_RD on the first cycle in which Start is sampled 0 after having been sampled 1; while Start=1 the block SHALL remain in IDLE.
REQ-018 INIT_RD: the block SHALL drive mem_addr=BASE_ENC and go to INIT.
REQ-019 INIT: the block SHALL latch init = mem_rd_data[6:0] ^ 7'h20, set p=0, set k=1, set s=step(init, tap[p]), and go to SRCH_RD.
REQ-020 SRCH_RD: the block SHALL drive mem_addr=BASE_ENC+k and go to SRCH_CMP.
REQ-021 SRCH_CMP on match: if (mem_rd_data[6:0] ^ s) == 7'h20, the block SHALL go to DEC_RD with i=0 and s=init when k == PRE_MIN-1, and otherwise SHALL advance s, increment k, and return to SRCH_RD.
REQ-022 SRCH_CMP on mismatch: the block SHALL increment p, set k=1, and set s=step(init, tap[p+1]); if p was 8, the block SHALL set Err=1, set tap_sel=0, and go to DONE without any memory writes.
REQ-023 DEC_RD: the block SHALL drive mem_addr=BASE_ENC+i and go to DEC_WR.
REQ-024 DEC_WR: the block SHALL drive mem_addr=i, mem_wr_en=1, and mem_wr_data={1'b0, mem_rd_data[6:0]^s}, then advance s and increment i; after i=63 it SHALL go to DONE, and otherwise SHALL return to DEC_RD.
REQ-025 mem_wr_en SHALL be high only in DEC_WR, with exactly 64 writes per successful run to addresses 0-63 in ascending order.
REQ-026 The i and k counters SHALL be 6 bits wide with no wrap past 63; BASE_ENC+i SHALL be computed at 8 bits.
REQ-027 Latency on a match at pattern index p SHALL be 2 + 18*p + 18 + 128 cycles from launch to DONE, with Ack=1 in the DONE cycle.
REQ-028 DONE: the block SHALL hold Ack, Err, and tap_sel stable while Start=0, and SHALL return to IDLE when Start=1 (Ack falls in that cycle).
REQ-029 A Start rising edge in any state other than IDLE or DONE SHALL abort the run and return the block to IDLE on the next cycle, leaving partial writes in memory.
REQ-030 Pattern search SHALL select the lowest-index pattern that matches all PRE_MIN preamble bytes.

Reset
REQ-031 While Reset_n=0, the block SHALL immediately force state=IDLE, Ack=0, Err=0, tap_sel=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and clear all counters and LFSR registers.
REQ-032 Reset assertion mid-run SHALL cancel the run with no further writes, and after release the block SHALL require a fresh 1-to-0 transition on Start.

Verification
REQ-033 Scenario: tap 0x7E, init 0x05, 64 encrypted spaces at addresses 64-127, Start released -> tap_sel=7, Err=0, 64 writes of 0x20, Ack after 2+126+18+128=274 cycles.
REQ-034 Scenario: tap 0x60, init 0x01, message "A joke is a very serious thing." with pre_length 12 -> tap_sel=0, addresses 0-63 equal the padded plaintext with bit7=0, and Ack after 148 cycles.
REQ-035 Scenario: parity bits randomly flipped on all 64 encrypted bytes -> output identical to the unflipped case.
REQ-036 Scenario: encrypted bytes 65-73 random such that no pattern matches -> Err=1, Ack=1, zero writes, and tap_sel=0.
REQ-037 Scenario: Reset_n pulsed low during DEC_WR at i=30 -> outputs zero immediately, no writes after the pulse, and no run until Start goes 1 then 0.
REQ-038 Scenario: Start raised during SRCH_CMP -> IDLE next cycle with Ack=0, and a subsequent Start release yields a correct full run.

Source files
------------

// File: rtl/decrypt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decrypt_ctrl                                                  |
// | Brief    : LFSR stream decryptor; finds the tap pattern from a space     |
// |            preamble, then writes 64 decrypted bytes to addresses 0-63.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module decrypt_ctrl #(
  parameter int BASE_ENC = 64,
  parameter int PRE_MIN  = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  output logic       Ack,
  output logic       Err,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [3:0] tap_sel
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_RD  = 3'd1,
    INIT     = 3'd2,
    SRCH_RD  = 3'd3,
    SRCH_CMP = 3'd4,
    DEC_RD   = 3'd5,
    DEC_WR   = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [7:0] c_base   = 8'(BASE_ENC);
  localparam logic [5:0] c_last_k = 6'(PRE_MIN - 1);
  localparam logic [5:0] c_last_i = 6'd63;
  localparam logic [3:0] c_last_p = 4'd8;
  localparam logic [6:0] c_space  = 7'h20;

  function automatic logic [6:0] tap_of(input logic [3:0] p);
    case (p)
      4'd0:    tap_of = 7'h60;
      4'd1:    tap_of = 7'h48;
      4'd2:    tap_of = 7'h78;
      4'd3:    tap_of = 7'h72;
      4'd4:    tap_of = 7'h6A;
      4'd5:    tap_of = 7'h69;
      4'd6:    tap_of = 7'h5C;
      4'd7:    tap_of = 7'h7E;
      4'd8:    tap_of = 7'h7B;
      default: tap_of = 7'h60;
    endcase
  endfunction

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] tap);
    step = {s[5:0], ^(s & tap)};
  endfunction

  state_t     r_state, w_state_nxt;
  logic       r_start_q;
  logic [6:0] r_init, w_init_nxt;
  logic [6:0] r_s, w_s_nxt;
  logic [3:0] r_p, w_p_nxt;
  logic [5:0] r_k, w_k_nxt;
  logic [5:0] r_i, w_i_nxt;
  logic       r_miss, w_miss_nxt;
  logic       r_err, w_err_nxt;
  logic [3:0] r_tap_sel, w_tap_sel_nxt;

  logic [6:0] w_code;
  logic [6:0] w_tap;
  logic       w_rise, w_fall, w_hit, w_miss_now;
  logic       w_unused_parity;

  // Bit 7 of every encrypted byte is parity and never enters the arithmetic.
  assign w_code          = mem_rd_data[6:0];
  assign w_unused_parity = mem_rd_data[7];
  assign w_tap           = tap_of(r_p);
  assign w_rise          = Start & ~r_start_q;
  assign w_fall          = ~Start & r_start_q;
  assign w_hit           = (w_code ^ r_s) == c_space;
  assign w_miss_now      = r_miss | ~w_hit;

  assign Err     = r_err;
  assign tap_sel = r_tap_sel;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_init    <= 7'd0;
      r_s       <= 7'd0;
      r_p       <= 4'd0;
      r_k       <= 6'd0;
      r_i       <= 6'd0;
      r_miss    <= 1'b0;
      r_err     <= 1'b0;
      r_tap_sel <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= Start;
      r_init    <= w_init_nxt;
      r_s       <= w_s_nxt;
      r_p       <= w_p_nxt;
      r_k       <= w_k_nxt;
      r_i       <= w_i_nxt;
      r_miss    <= w_miss_nxt;
      r_err     <= w_err_nxt;
      r_tap_sel <= w_tap_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_init_nxt    = r_init;
    w_s_nxt       = r_s;
    w_p_nxt       = r_p;
    w_k_nxt       = r_k;
    w_i_nxt       = r_i;
    w_miss_nxt    = r_miss;
    w_err_nxt     = r_err;
    w_tap_sel_nxt = r_tap_sel;
    Ack           = 1'b0;
    mem_addr      = 8'd0;
    mem_wr_en     = 1'b0;
    mem_wr_data   = 8'd0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt   = INIT_RD;
          w_err_nxt     = 1'b0;
          w_tap_sel_nxt = 4'd0;
        end
      end
      INIT_RD: begin
        mem_addr    = c_base;
        w_state_nxt = INIT;
      end
      INIT: begin
        w_init_nxt  = w_code ^ c_space;
        w_p_nxt     = 4'd0;
        w_k_nxt     = 6'd1;
        w_miss_nxt  = 1'b0;
        w_s_nxt     = step(w_code ^ c_space, tap_of(4'd0));
        w_state_nxt = SRCH_RD;
      end
      SRCH_RD: begin
        mem_addr    = c_base + {2'b00, r_k};
        w_state_nxt = SRCH_CMP;
      end
      SRCH_CMP: begin
        // Every candidate scans the full preamble before being judged, so the
        // search time per pattern is constant and independent of the data.
        if (r_k == c_last_k) begin
          if (!w_miss_now) begin
            w_tap_sel_nxt = r_p;
            w_i_nxt       = 6'd0;
            w_s_nxt       = r_init;
            w_state_nxt   = DEC_RD;
          end else if (r_p == c_last_p) begin
            w_err_nxt     = 1'b1;
            w_tap_sel_nxt = 4'd0;
            w_state_nxt   = DONE;
          end else begin
            w_p_nxt     = r_p + 4'd1;
            w_k_nxt     = 6'd1;
            w_miss_nxt  = 1'b0;
            w_s_nxt     = step(r_init, tap_of(r_p + 4'd1));
            w_state_nxt = SRCH_RD;
          end
        end else begin
          w_s_nxt     = step(r_s, w_tap);
          w_k_nxt     = r_k + 6'd1;
          w_miss_nxt  = w_miss_now;
          w_state_nxt = SRCH_RD;
        end
      end
      DEC_RD: begin
        mem_addr    = c_base + {2'b00, r_i};
        w_state_nxt = DEC_WR;
      end
      DEC_WR: begin
        mem_addr    = {2'b00, r_i};
        mem_wr_en   = 1'b1;
        mem_wr_data = {1'b0, w_code ^ r_s};
        w_s_nxt     = step(r_s, w_tap);
        if (r_i == c_last_i) begin
          w_state_nxt = DONE;
        end else begin
          w_i_nxt     = r_i + 6'd1;
          w_state_nxt = DEC_RD;
        end
      end
      DONE: begin
        Ack = 1'b1;
        if (Start) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_rise && (r_state != IDLE) && (r_state != DONE)) begin
      w_state_nxt = IDLE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_decrypt_ctrl                                               |
// | Brief    : Directed self-checking bench for decrypt_ctrl.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_decrypt_ctrl;

  localparam int BASE = 64;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic       Ack;
  logic       Err;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [3:0] tap_sel;

  logic [7:0] enc_mem [256];
  logic [7:0] out_mem [64];
  logic [7:0] pt      [64];
  logic [7:0] last_addr = 8'd0;
  bit         order_bad = 1'b0;
  int         wcnt      = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;

  always #5 Clk = ~Clk;

  decrypt_ctrl #(
    .BASE_ENC (64),
    .PRE_MIN  (10)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Ack         (Ack),
    .Err         (Err),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .tap_sel     (tap_sel)
  );

  // Synchronous data memory: encrypted image above BASE, plaintext below.
  always @(posedge Clk) begin
    mem_rd_data <= enc_mem[mem_addr];
    if (mem_wr_en) begin
      if (mem_addr < 8'd64) out_mem[mem_addr[5:0]] <= mem_wr_data;
      if ((mem_addr >= 8'd64) || !((mem_addr == 8'd0) || (mem_addr == last_addr + 8'd1)))
        order_bad <= 1'b1;
      last_addr <= mem_addr;
      wcnt      <= wcnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lfsr(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  task automatic set_message(input string msg, input int pre);
    for (int j = 0; j < 64; j++) pt[j] = 8'h20;
    for (int j = 0; j < msg.len(); j++) pt[pre + j] = msg[j];
  endtask

  task automatic load_image(input logic [6:0] tap, input logic [6:0] init, input bit rand_par);
    logic [6:0] s;
    logic       par;
    s = init;
    for (int j = 0; j < 64; j++) begin
      par = rand_par ? 1'($urandom_range(1)) : 1'b0;
      enc_mem[BASE + j] = {par, pt[j][6:0] ^ s};
      s = lfsr(s, tap);
    end
  endtask

  task automatic check_plain(input string tag);
    for (int j = 0; j < 64; j++)
      check_eq($sformatf("%s[%0d]", tag, j), {24'd0, out_mem[j]}, {24'd0, 1'b0, pt[j][6:0]});
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ack"},   {31'd0, Ack},       32'd0);
    check_eq({tag, "_err"},   {31'd0, Err},       32'd0);
    check_eq({tag, "_tap"},   {28'd0, tap_sel},   32'd0);
    check_eq({tag, "_wren"},  {31'd0, mem_wr_en}, 32'd0);
    check_eq({tag, "_addr"},  {24'd0, mem_addr},  32'd0);
    check_eq({tag, "_wdata"}, {24'd0, mem_wr_data}, 32'd0);
  endtask

  // Pulses Start high then low; lat = clock edges after the launch edge until Ack.
  task automatic run(output int lat);
    @(negedge Clk) Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    lat = 0;
    while (!Ack && lat < 2000) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int  lat;
    int  w0;
    bit  found;
    Reset_n = 1'b0;
    Start   = 1'b1;
    for (int j = 0; j < 256; j++) enc_mem[j] = 8'h00;
    repeat (3) @(negedge Clk);
    check_zero_outputs("reset");
    Reset_n = 1'b1;

    // 64 spaces, tap 0x7E (index 7), init 0x05
    set_message("", 0);
    load_image(7'h7E, 7'h05, 1'b0);
    w0 = wcnt;
    run(lat);
    check_eq("spc_lat", lat, 274);
    check_eq("spc_err", {31'd0, Err}, 0);
    check_eq("spc_tap", {28'd0, tap_sel}, 7);
    check_eq("spc_writes", wcnt - w0, 64);
    check_plain("spc");
    repeat (5) @(negedge Clk);
    check_eq("spc_hold_ack", {31'd0, Ack}, 1);
    check_eq("spc_hold_tap", {28'd0, tap_sel}, 7);

    // Message, tap 0x60 (index 0), init 0x01, 12-space preamble
    set_message("A joke is a very serious thing.", 12);
    load_image(7'h60, 7'h01, 1'b0);
    w0 = wcnt;
    run(lat);
    check_eq("msg_lat", lat, 148);
    check_eq("msg_err", {31'd0, Err}, 0);
    check_eq("msg_tap", {28'd0, tap_sel}, 0);
    check_eq("msg_writes", wcnt - w0, 64);
    check_plain("msg");

    // Same message with random parity bits: result must not change
    load_image(7'h60, 7'h01, 1'b1);
    w0 = wcnt;
    run(lat);
    check_eq("par_lat", lat, 148);
    check_eq("par_tap", {28'd0, tap_sel}, 0);
    check_eq("par_writes", wcnt - w0, 64);
    check_plain("par");

    // init = 0 keeps every LFSR at zero; byte 65 != space defeats all taps
    for (int j = 0; j < 64; j++) enc_mem[BASE + j] = 8'($urandom);
    enc_mem[BASE]     = 8'hA0;
    enc_mem[BASE + 1] = 8'hC1;
    w0 = wcnt;
    run(lat);
    check_eq("nm_ack", {31'd0, Ack}, 1);
    check_eq("nm_err", {31'd0, Err}, 1);
    check_eq("nm_tap", {28'd0, tap_sel}, 0);
    check_eq("nm_writes", wcnt - w0, 0);
    check_eq("nm_order", {31'd0, order_bad}, 0);

    // Abort by raising Start while in SRCH_CMP
    load_image(7'h60, 7'h01, 1'b0);
    @(negedge Clk) Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    repeat (2) @(posedge Clk);
    #1;
    check_eq("ab_srch_addr", {24'd0, mem_addr}, 65);
    @(posedge Clk);
    #1;
    Start = 1'b1;
    w0 = wcnt;
    @(posedge Clk);
    #1;
    check_eq("ab_ack", {31'd0, Ack}, 0);
    check_eq("ab_addr", {24'd0, mem_addr}, 0);
    repeat (5) @(negedge Clk);
    check_eq("ab_idle_addr", {24'd0, mem_addr}, 0);
    check_eq("ab_writes", wcnt - w0, 0);
    w0 = wcnt;
    run(lat);
    check_eq("ab_run_lat", lat, 148);
    check_eq("ab_run_err", {31'd0, Err}, 0);
    check_eq("ab_run_tap", {28'd0, tap_sel}, 0);
    check_eq("ab_run_writes", wcnt - w0, 64);
    check_plain("ab_run");

    // Reset pulse while DEC_WR presents i = 30
    set_message("", 0);
    load_image(7'h7E, 7'h05, 1'b0);
    @(negedge Clk) Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    w0 = wcnt;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge Clk);
      #1;
      if (mem_wr_en && mem_addr == 8'd30) found = 1'b1;
    end
    check_eq("rst_reached_i30", {31'd0, found}, 1);
    Reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    check_eq("rst_writes_before", wcnt - w0, 30);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check_eq("rst_no_relaunch_ack", {31'd0, Ack}, 0);
    check_eq("rst_no_relaunch_addr", {24'd0, mem_addr}, 0);
    check_eq("rst_writes_after", wcnt - w0, 30);
    w0 = wcnt;
    run(lat);
    check_eq("rst_run_lat", lat, 274);
    check_eq("rst_run_tap", {28'd0, tap_sel}, 7);
    check_eq("rst_run_writes", wcnt - w0, 64);
    check_plain("rst_run");
    check_eq("order", {31'd0, order_bad}, 0);

    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    #1;
    check_eq("done_exit_ack", {31'd0, Ack}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
